dac_table_8x_hls_axis_stall_detector: RTL and testbench

Upstream feeder of the dac_table_8x deadlock monitor. Passively observes the AXI-Stream handshakes of dac_table_8x_inst and produces one registered per-stream block flag. The monitor ORs these flags into its block output. A flag asserts only after a stream has been stalled for a programmable number of consecutive cycles. Sticky status and first-blocked-stream capture are provided for debug readout.

---
 rtl/dac_table_8x_hls_dbg_pkg.sv | 18 +
 rtl/dac_table_8x_hls_axis_stall_detector_if.sv | 15 +
 rtl/dac_table_8x_hls_stall_chan.sv | 93 +++++++++
 rtl/dac_table_8x_hls_axis_stall_detector.sv | 74 +++++++
 tb/tb_dac_table_8x_hls_axis_stall_detector.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/dac_table_8x_hls_dbg_pkg.sv
// Shared definitions for the dac_table_8x AXIS stall detector and deadlock monitor.
package dac_table_8x_hls_dbg_pkg;

  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_THRESH_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    BLOCKED = 2'd2
  } stall_state_e;

  // A programmed threshold of zero behaves like one stall cycle.
  function automatic logic [31:0] effective_thresh(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/dac_table_8x_hls_axis_stall_detector_if.sv
// Observed AXI-Stream handshake bundle: one TVALID/TREADY pair per stream.
interface dac_table_8x_hls_axis_stall_detector_if
  import dac_table_8x_hls_dbg_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);

  logic [NUM_CH-1:0] tvalid;
  logic [NUM_CH-1:0] tready;

  // The environment drives the handshakes; the detector only watches them.
  modport master (output tvalid, output tready);
  modport slave  (input  tvalid, input  tready);

endinterface

// File: rtl/dac_table_8x_hls_stall_chan.sv
// One observed stream: stall decode, consecutive-stall counter and IDLE/COUNT/BLOCKED FSM.
module dac_table_8x_hls_stall_chan
  import dac_table_8x_hls_dbg_pkg::*;
#(
  parameter bit IS_OUT   = 1'b0,
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_enable,
  input  logic [THRESH_W-1:0] i_thresh,
  input  logic                i_tvalid,
  input  logic                i_tready,
  output logic                o_block,
  output logic                o_enter
);

  stall_state_e        r_state, w_state_next;
  logic [THRESH_W-1:0] r_cnt, w_cnt_next, w_cnt_sat;
  logic [THRESH_W:0]   w_cnt_inc, w_eq;
  logic                r_block;
  logic                w_stall;

  // Output stream stalls when backpressured; input stream stalls when starved.
  assign w_stall   = IS_OUT ? (i_tvalid & ~i_tready) : (i_tready & ~i_tvalid);
  // One extra bit keeps cnt+1 from wrapping when compared against a lowered threshold.
  assign w_eq      = (THRESH_W+1)'(effective_thresh(32'(i_thresh)));
  assign w_cnt_inc = {1'b0, r_cnt} + (THRESH_W+1)'(1);
  assign w_cnt_sat = (&r_cnt) ? r_cnt : r_cnt + THRESH_W'(1);

  // Next-state and next-count decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!i_enable) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_stall) begin
            w_cnt_next   = THRESH_W'(1);
            w_state_next = (w_eq == (THRESH_W+1)'(1)) ? BLOCKED : COUNT;
          end else begin
            w_cnt_next   = '0;
          end
        end
        COUNT: begin
          if (w_stall) begin
            w_cnt_next = w_cnt_sat;
            if (w_cnt_inc >= w_eq) w_state_next = BLOCKED;
          end else begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end
        end
        BLOCKED: begin
          if (w_stall) begin
            w_cnt_next   = w_cnt_sat;
          end else begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end
        end
        default: begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Rising edge of the block flag, registered by the top into sticky/capture state.
  assign o_enter = (w_state_next == BLOCKED) && (r_state != BLOCKED);

  // State, counter and flag registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_block <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_block <= (w_state_next == BLOCKED);
    end
  end

  assign o_block = r_block;

endmodule

// File: rtl/dac_table_8x_hls_axis_stall_detector.sv
// Per-stream stall detector: channel FSMs, sticky status and first-blocked capture.
module dac_table_8x_hls_axis_stall_detector
  import dac_table_8x_hls_dbg_pkg::*;
#(
  parameter int                NUM_CH    = DEF_NUM_CH,
  parameter logic [NUM_CH-1:0] CH_IS_OUT = NUM_CH'(3'b100),
  parameter int                THRESH_W  = DEF_THRESH_W,
  parameter int                IDX_W     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [THRESH_W-1:0]   thresh,
  input  logic                  clear,
  dac_table_8x_hls_axis_stall_detector_if.slave axis,
  output logic [NUM_CH-1:0]     axis_block_sigs,
  output logic [NUM_CH-1:0]     stall_sticky,
  output logic                  first_valid,
  output logic [IDX_W-1:0]      first_ch
);

  logic [NUM_CH-1:0] w_block, w_enter;
  logic [NUM_CH-1:0] r_sticky;
  logic              r_first_valid;
  logic [IDX_W-1:0]  r_first_ch, w_first_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    dac_table_8x_hls_stall_chan #(
      .IS_OUT   (CH_IS_OUT[g]),
      .THRESH_W (THRESH_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .i_enable (enable),
      .i_thresh (thresh),
      .i_tvalid (axis.tvalid[g]),
      .i_tready (axis.tready[g]),
      .o_block  (w_block[g]),
      .o_enter  (w_enter[g])
    );
  end

  // Lowest-indexed channel entering BLOCKED this cycle.
  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_enter[i]) w_first_idx = IDX_W'(i);
    end
  end

  // Sticky status and first-blocked capture; a new block beats a coincident clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sticky      <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
    end else begin
      r_sticky <= (r_sticky & ~{NUM_CH{clear}}) | w_enter;
      if ((!r_first_valid || clear) && (|w_enter)) begin
        r_first_valid <= 1'b1;
        r_first_ch    <= w_first_idx;
      end else if (clear) begin
        r_first_valid <= 1'b0;
        r_first_ch    <= '0;
      end
    end
  end

  assign axis_block_sigs = w_block;
  assign stall_sticky    = r_sticky;
  assign first_valid     = r_first_valid;
  assign first_ch        = r_first_ch;

endmodule

// File: tb/tb_dac_table_8x_hls_axis_stall_detector.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares every cycle.
module tb_dac_table_8x_hls_axis_stall_detector;
  import dac_table_8x_hls_dbg_pkg::*;

  localparam int         NUM_CH   = 3;
  localparam int         THRESH_W = 16;
  localparam int         IDX_W    = 2;
  localparam logic [2:0] IS_OUT   = 3'b100;

  logic                clock = 1'b0;
  logic                reset, enable, clear;
  logic [THRESH_W-1:0] thresh;
  logic [NUM_CH-1:0]   axis_block_sigs, stall_sticky;
  logic                first_valid;
  logic [IDX_W-1:0]    first_ch;

  dac_table_8x_hls_axis_stall_detector_if #(.NUM_CH(NUM_CH)) axis_if ();

  dac_table_8x_hls_axis_stall_detector #(
    .NUM_CH    (NUM_CH),
    .CH_IS_OUT (IS_OUT),
    .THRESH_W  (THRESH_W),
    .IDX_W     (IDX_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .thresh          (thresh),
    .clear           (clear),
    .axis            (axis_if),
    .axis_block_sigs (axis_block_sigs),
    .stall_sticky    (stall_sticky),
    .first_valid     (first_valid),
    .first_ch        (first_ch)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] blk;
    logic [2:0] sticky;
    logic       fv;
    logic [1:0] fch;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: consecutive-stall run length per stream.
  int         m_run [NUM_CH];
  logic [2:0] m_blk    = '0;
  logic [2:0] m_sticky = '0;
  logic       m_fv     = 1'b0;
  logic [1:0] m_fch    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    int         eq;
    logic       stall;
    logic [2:0] nb, enter;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      m_blk = '0; m_sticky = '0; m_fv = 1'b0; m_fch = '0;
    end else begin
      eq = (thresh == 0) ? 1 : int'(thresh);
      nb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stall = IS_OUT[i] ? (axis_if.tvalid[i] && !axis_if.tready[i])
                          : (axis_if.tready[i] && !axis_if.tvalid[i]);
        if (enable && stall) begin
          m_run[i] = (m_run[i] < 65535) ? m_run[i] + 1 : 65535;
          nb[i]    = m_blk[i] || (m_run[i] >= eq);
        end else begin
          m_run[i] = 0;
        end
      end
      enter    = nb & ~m_blk;
      m_sticky = (clear ? 3'b000 : m_sticky) | enter;
      if ((!m_fv || clear) && (enter != 3'b000)) begin
        m_fv = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (enter[i]) m_fch = 2'(i);
      end else if (clear) begin
        m_fv = 1'b0; m_fch = '0;
      end
      m_blk = nb;
    end
    sb.push_back('{blk: m_blk, sticky: m_sticky, fv: m_fv, fch: m_fch});
  endtask

  // Apply inputs for n cycles; each cycle pushes its expectation then waits to the falling edge.
  task automatic drive(input logic r, input logic en, input logic clr, input logic [15:0] th,
                       input logic [2:0] tv, input logic [2:0] tr, input int n);
    for (int k = 0; k < n; k++) begin
      reset = r; enable = en; clear = clr; thresh = th;
      axis_if.tvalid = tv; axis_if.tready = tr;
      model_step();
      @(negedge clock);
    end
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("sb_block",  32'(axis_block_sigs), 32'(mon_e.blk));
      check("sb_sticky", 32'(stall_sticky),    32'(mon_e.sticky));
      check("sb_fvalid", 32'(first_valid),     32'(mon_e.fv));
      check("sb_fch",    32'(first_ch),        32'(mon_e.fch));
    end
  end

  logic [2:0]  r_tv, r_tr;
  logic [15:0] r_th;

  initial begin
    for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
    drive(1, 0, 0, 4, 3'b000, 3'b000, 2);
    check("reset_block",  32'(axis_block_sigs), 0);
    check("reset_sticky", 32'(stall_sticky), 0);
    check("reset_first",  32'({first_valid, first_ch}), 0);

    // Reset in the middle of a count restarts it.
    drive(0, 1, 0, 4, 3'b000, 3'b001, 3);
    check("midcnt_pre", 32'(axis_block_sigs), 0);
    drive(1, 1, 0, 4, 3'b000, 3'b001, 1);
    check("midcnt_rst", 32'({first_valid, stall_sticky, axis_block_sigs}), 0);
    drive(0, 1, 0, 4, 3'b000, 3'b001, 3);
    check("midcnt_3", 32'(axis_block_sigs), 0);
    drive(0, 1, 0, 4, 3'b000, 3'b001, 1);
    check("midcnt_4", 32'(axis_block_sigs), 3'b001);

    // Threshold 5 on output stream ch2, released by tready.
    drive(0, 1, 1, 5, 3'b000, 3'b000, 1);
    drive(0, 1, 0, 5, 3'b100, 3'b000, 4);
    check("th5_early", 32'(axis_block_sigs), 0);
    drive(0, 1, 0, 5, 3'b100, 3'b000, 1);
    check("th5_rise", 32'(axis_block_sigs), 3'b100);
    drive(0, 1, 0, 5, 3'b100, 3'b000, 5);
    drive(0, 1, 0, 5, 3'b100, 3'b100, 1);
    check("th5_drop", 32'(axis_block_sigs), 0);
    check("th5_sticky", 32'(stall_sticky), 3'b100);

    // Broken run on input stream ch1 never reaches threshold.
    drive(0, 1, 0, 4, 3'b000, 3'b010, 3);
    drive(0, 1, 0, 4, 3'b000, 3'b000, 1);
    drive(0, 1, 0, 4, 3'b000, 3'b010, 3);
    check("broken_blk", 32'(axis_block_sigs[1]), 0);
    check("broken_sticky", 32'(stall_sticky[1]), 0);
    drive(0, 1, 0, 4, 3'b000, 3'b000, 1);

    // Threshold zero behaves as one: single stall cycle gives a one-cycle flag.
    drive(0, 1, 0, 0, 3'b000, 3'b001, 1);
    check("th0_high", 32'(axis_block_sigs), 3'b001);
    drive(0, 1, 0, 0, 3'b000, 3'b000, 1);
    check("th0_low", 32'(axis_block_sigs), 0);

    // Simultaneous block capture, then clear coincident with a re-block.
    drive(0, 1, 1, 3, 3'b000, 3'b000, 1);
    check("cap_cleared", 32'(first_valid), 0);
    drive(0, 1, 0, 3, 3'b100, 3'b010, 3);
    check("cap_blk", 32'(axis_block_sigs), 3'b110);
    check("cap_first", 32'({first_valid, first_ch}), 3'b101);
    drive(0, 1, 0, 1, 3'b000, 3'b010, 1);
    check("cap_release", 32'(axis_block_sigs), 3'b010);
    drive(0, 1, 1, 1, 3'b100, 3'b010, 1);
    check("cap_reblock", 32'({first_valid, first_ch}), 3'b110);
    check("cap_sticky", 32'(stall_sticky), 3'b100);

    // Disable during a held stall: flags clear, status held.
    drive(0, 0, 0, 1, 3'b100, 3'b010, 1);
    check("dis_blk", 32'(axis_block_sigs), 0);
    check("dis_sticky", 32'(stall_sticky), 3'b100);
    check("dis_first", 32'({first_valid, first_ch}), 3'b110);

    // Long idle with no handshake activity.
    drive(0, 1, 0, 3, 3'b000, 3'b000, 1000);
    check("idle_blk", 32'(axis_block_sigs), 0);

    // Randomized phase with held handshake levels so stalls run long.
    r_tv = 3'b000; r_tr = 3'b000; r_th = 16'd3;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) r_tv = 3'($urandom);
      if ($urandom_range(0, 5) == 0) r_tr = 3'($urandom);
      if ($urandom_range(0, 99) == 0) r_th = 16'($urandom_range(0, 6));
      drive(logic'($urandom_range(0, 499) == 0), logic'($urandom_range(0, 99) != 0),
            logic'($urandom_range(0, 49) == 0), r_th, r_tv, r_tr, 1);
    end

    @(posedge clock);
    #2;
    check("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
